btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//   Front end for the push-buttons on the ALU test board. Synchronises raw button inputs into clk,
//   removes contact bounce and emits a one-cycle press pulse per physical press. The operand/opcode
//   capture FSM consumes these pulses, so one press advances it exactly one state.
//   Also provides a clean debounced level and a release pulse for each button.
// PARAMETERS
//   N_BTN            4           number of independent button channels
//   SYNC_STAGES      2           flip-flops in the metastability synchroniser (>=2)
//   DEBOUNCE_CYCLES  1_000_000   consecutive stable cycles needed to accept a change (10 ms @100 MHz; >=2)
//   REPEAT_DELAY     50_000_000  cycles from press to first auto-repeat (used only with BTN_AUTOREPEAT_EN)
//   REPEAT_PERIOD    10_000_000  cycles between later auto-repeats (used only with BTN_AUTOREPEAT_EN)
// PORTS
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous reset, active-low
//   btn_raw      in   N_BTN  raw, asynchronous button inputs, 1 = pressed
//   btn_level    out  N_BTN  debounced level, registered
//   btn_press    out  N_BTN  one-cycle pulse on an accepted 0->1 (and on auto-repeat when enabled)
//   btn_release  out  N_BTN  one-cycle pulse on an accepted 1->0
// BEHAVIOUR
//   - One clock (clk). Reset is asynchronous and active-low (rst_n).
//   - While rst_n=0, all of the following are 0: sync chain, btn_level, btn_press, btn_release,
//     the counters and the repeat state.
//   - Asserting rst_n mid-count aborts the count immediately. After reset, a held button counts as a new press.
//   - Channels are fully independent. Simultaneous changes on several channels produce pulses in the same cycle.
//   - Per-channel datapath:
//     - sync = last stage of the SYNC_STAGES chain.
//     - cnt has width $clog2(DEBOUNCE_CYCLES).
//   - Per-channel update on each clk edge:
//     - If sync == btn_level: cnt <= 0.
//     - Else if cnt == DEBOUNCE_CYCLES-1: btn_level <= sync and cnt <= 0. btn_press (or btn_release)
//       asserts for that one cycle.
//     - Else: cnt <= cnt + 1.
//   - Latency: a clean raw edge changes btn_level on exactly edge SYNC_STAGES+DEBOUNCE_CYCLES after
//     the edge that first samples the new raw value. The pulse asserts in the same cycle.
//   - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles resets cnt. Such a glitch never
//     changes the level and never produces a pulse.
//   - btn_press and btn_release are never both high on one channel in the same cycle.
//   - Each pulse is exactly 1 cycle wide.
//   - The counter saturates at its compare point; no wrap-around can occur.
// CONFIGURATION
//   BTN_AUTOREPEAT_EN defined:
//     - A per-channel repeat counter runs while btn_level=1 and clears on btn_level=0 or reset.
//     - Extra btn_press pulses occur REPEAT_DELAY cycles after the accepted press, then every
//       REPEAT_PERIOD cycles while the button is held.
//     - btn_release behaviour is unchanged.
//   BTN_AUTOREPEAT_EN undefined:
//     - No repeat logic is synthesised; REPEAT_* are ignored.
//     - Exactly one btn_press per accepted press.
// STRUCTURE
//   btn_pkg holds:
//     - default constants: DEBOUNCE_CYCLES_100MHZ, REPEAT_DELAY_100MHZ, REPEAT_PERIOD_100MHZ, SYNC_STAGES_DEF
//     - a cnt-width helper function
//   Sub-module btn_debounce_ch contains one channel: synchroniser, debounce counter, level/pulse
//   registers and optional repeat counter.
//   btn_debounce instantiates btn_debounce_ch N_BTN times in a generate loop. No shared state.
// TESTING
//   Bench parameters: N_BTN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
//   1. Reset:
//      - Stimulus: rst_n=0 with btn_raw=4'hF for 5 cycles, then release reset with btn_raw=4'hF held.
//      - Required: all outputs 0 during reset; btn_press=4'hF for one cycle at edge 6; btn_level=4'hF after that.
//   2. Clean press:
//      - Stimulus: btn_raw[0] goes 0->1 and is held 12 cycles.
//      - Required: btn_level[0] rises at edge 6; btn_press[0] high for exactly 1 cycle; btn_release stays 0.
//   3. Bounce:
//      - Stimulus: btn_raw[1] = 1,0,1,0,1 (2 cycles each), then held at 1.
//      - Required: no pulse during the bounce; exactly one btn_press[1], 6 edges after the final 0->1.
//   4. Simultaneous:
//      - Stimulus: btn_raw goes 4'b0000 -> 4'b1010 in one cycle.
//      - Required: btn_press=4'b1010 in a single cycle; later, on 4'b1010->4'b0000, btn_release=4'b1010 in one cycle.
//   5. Reset mid-count:
//      - Stimulus: drive rst_n low 2 cycles after a press edge, then release.
//      - Required: outputs 0 immediately (async); the press is re-detected at edge 6 after reset release.
//   6. Auto-repeat:
//      - Stimulus: hold btn_raw[2] for 25 cycles after acceptance at cycle t.
//      - Required with BTN_AUTOREPEAT_EN: btn_press[2] at t, t+8, t+11, t+14, ...
//      - Required without BTN_AUTOREPEAT_EN: btn_press[2] only at t.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants, the counter-width helper and the repeat phase type
// for the push-button debounce front end.
package btn_pkg;

   localparam int DEBOUNCE_CYCLES_100MHZ = 1_000_000;
   localparam int REPEAT_DELAY_100MHZ    = 50_000_000;
   localparam int REPEAT_PERIOD_100MHZ   = 10_000_000;
   localparam int SYNC_STAGES_DEF        = 2;

   typedef enum logic {
      RPT_DELAY,
      RPT_PERIOD
   } rpt_phase_e;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle between the raw board inputs and the debounced outputs.
// master drives btn_raw; slave (the debouncer) drives the clean outputs.
interface btn_debounce_if #(
   parameter int N_BTN = 4
);

   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release
   );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce counter, level/pulse regs.
// BTN_AUTOREPEAT_EN adds a repeat counter that re-fires press while held.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_100MHZ,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MHZ
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rls
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   sync;
   logic                   accept;
   logic                   rpt_due;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign accept = (sync != level) && (cnt_q == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   // cnt only advances while sync disagrees, so it never passes CNT_MAX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         level <= 1'b0;
      end else if (sync == level) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_q <= '0;
         level <= sync;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         press <= 1'b0;
         rls   <= 1'b0;
      end else begin
         press <= (accept && sync) || rpt_due;
         rls   <= accept && !sync;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RW = cnt_width(
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

   rpt_phase_e    phase_q;
   logic [RW-1:0] rpt_q;
   logic [RW-1:0] rpt_lim;

   assign rpt_lim = (phase_q == RPT_PERIOD) ? RPT_NEXT : RPT_FIRST;
   // an accepted release wins over a repeat landing on the same edge
   assign rpt_due = level && !accept && (rpt_q == rpt_lim);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= RPT_DELAY;
         rpt_q   <= '0;
      end else if (!level || accept) begin
         phase_q <= RPT_DELAY;
         rpt_q   <= '0;
      end else if (rpt_due) begin
         phase_q <= RPT_PERIOD;
         rpt_q   <= '0;
      end else begin
         rpt_q   <= rpt_q + 1'b1;
      end
   end
`else
   logic unused_rpt;

   assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
   assign rpt_due    = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: N_BTN independent debounce channels.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat press pulses.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_100MHZ,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MHZ
) (
   input  logic          clk,
   input  logic          rst_n,
   btn_debounce_if.slave bus
);

   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] rls;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (bus.btn_raw[i]),
         .level (level[i]),
         .press (press[i]),
         .rls   (rls[i])
      );
   end

   assign bus.btn_level   = level;
   assign bus.btn_press   = press;
   assign bus.btn_release = rls;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random bouncing,
// checked every cycle against a sliding-window reference model.
`timescale 1ns/1ps
module tb_btn_debounce;

   localparam int N  = 4;
   localparam int SS = 2;
   localparam int DC = 4;
   localparam int RD = 8;
   localparam int RP = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   btn_debounce_if #(.N_BTN(N)) bus ();

   btn_debounce #(
      .N_BTN           (N),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DC),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check4(input string name,
                         input logic [N-1:0] act,
                         input logic [N-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check32(input string name,
                          input logic [31:0] act,
                          input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a channel flips when the last DC synchronised
   // samples (raw seen SS edges earlier) all differ from its level.
   logic [N-1:0] m_level = '0;
   logic [N-1:0] m_press = '0;
   logic [N-1:0] m_rls   = '0;
   logic [N-1:0] hist[$];
   int           held[N];
   int           press_cnt[N];

   function automatic logic raw_at(input int e, input int c);
      if (e < 1 || e > hist.size()) return 1'b0;
      return hist[e-1][c];
   endfunction

   initial begin
      bit flip;
      int n;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            hist.delete();
            m_level = '0;
            m_press = '0;
            m_rls   = '0;
            for (int c = 0; c < N; c++) held[c] = 0;
         end else begin
            hist.push_back(bus.btn_raw);
            n = hist.size();
            m_press = '0;
            m_rls   = '0;
            for (int c = 0; c < N; c++) begin
               flip = 1'b1;
               for (int e = n - SS - DC + 1; e <= n - SS; e++)
                  if (raw_at(e, c) == m_level[c]) flip = 1'b0;
               if (flip) begin
                  m_level[c] = ~m_level[c];
                  if (m_level[c]) m_press[c] = 1'b1;
                  else            m_rls[c]   = 1'b1;
                  held[c] = 0;
               end else if (m_level[c]) begin
                  held[c]++;
`ifdef BTN_AUTOREPEAT_EN
                  if (held[c] >= RD && (held[c] - RD) % RP == 0)
                     m_press[c] = 1'b1;
`endif
               end
            end
         end
         #1;
         check4("level",   bus.btn_level,   m_level);
         check4("press",   bus.btn_press,   m_press);
         check4("release", bus.btn_release, m_rls);
         for (int c = 0; c < N; c++)
            if (bus.btn_press[c]) press_cnt[c]++;
      end
   end

   task automatic drive(input logic [N-1:0] v);
      @(negedge clk);
      bus.btn_raw = v;
   endtask

   task automatic edges(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          c0;
      logic [31:0] seen;
      logic [31:0] exp_mask;
      logic [N-1:0] v;

      bus.btn_raw = 4'hF;
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check4("rst_level",   bus.btn_level,   4'h0);
      check4("rst_press",   bus.btn_press,   4'h0);
      check4("rst_release", bus.btn_release, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      edges(5);
      check4("t1_press_e5", bus.btn_press, 4'h0);
      edges(1);
      check4("t1_press_e6", bus.btn_press, 4'hF);
      check4("t1_model_e6", m_press,       4'hF);
      edges(1);
      check4("t1_press_e7", bus.btn_press, 4'h0);
      check4("t1_level_e7", bus.btn_level, 4'hF);
      drive(4'h0);
      edges(10);

      c0 = press_cnt[0];
      drive(4'b0001);
      edges(5);
      check4("t2_level_e5", bus.btn_level, 4'h0);
      edges(1);
      check4("t2_press_e6", bus.btn_press, 4'b0001);
      check4("t2_level_e6", bus.btn_level, 4'b0001);
      edges(1);
      check4("t2_press_e7", bus.btn_press, 4'h0);
      check32("t2_npress", 32'(press_cnt[0] - c0), 32'd1);
      edges(5);
      drive(4'h0);
      edges(10);

      c0 = press_cnt[1];
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.btn_raw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         repeat (2) @(negedge clk);
      end
      bus.btn_raw = 4'b0010;
      edges(5);
      check32("t3_bounce_npress", 32'(press_cnt[1] - c0), 32'd0);
      edges(1);
      check4("t3_press_e6", bus.btn_press, 4'b0010);
      check32("t3_npress", 32'(press_cnt[1] - c0), 32'd1);
      drive(4'h0);
      edges(12);

      drive(4'b1010);
      edges(5);
      check4("t4_press_e5", bus.btn_press, 4'h0);
      edges(1);
      check4("t4_press_e6", bus.btn_press, 4'b1010);
      edges(1);
      check4("t4_press_e7", bus.btn_press, 4'h0);
      drive(4'h0);
      edges(5);
      check4("t4_rel_e5", bus.btn_release, 4'h0);
      edges(1);
      check4("t4_rel_e6", bus.btn_release, 4'b1010);
      edges(1);
      check4("t4_rel_e7", bus.btn_release, 4'h0);
      edges(5);

      drive(4'b0001);
      edges(10);
      drive(4'b1001);
      edges(2);
      #1;
      rst_n = 1'b0;
      #1;
      check4("t5_rst_level", bus.btn_level, 4'h0);
      check4("t5_rst_press", bus.btn_press, 4'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      edges(5);
      check4("t5_press_e5", bus.btn_press, 4'h0);
      edges(1);
      check4("t5_press_e6", bus.btn_press, 4'b1001);
      check4("t5_level_e6", bus.btn_level, 4'b1001);
      drive(4'h0);
      edges(12);

      seen = '0;
      drive(4'b0100);
      for (int e = 1; e <= 31; e++) begin
         edges(1);
         if (bus.btn_press[2]) seen[e] = 1'b1;
      end
`ifdef BTN_AUTOREPEAT_EN
      exp_mask = 32'h2492_4040;
`else
      exp_mask = 32'h0000_0040;
`endif
      check32("t6_press_mask", seen, exp_mask);
      drive(4'h0);
      edges(12);

      v = '0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 149) == 0) begin
            rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
         end
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 5) == 0) v[c] = ~v[c];
         bus.btn_raw = v;
      end
      edges(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
